// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// Optional instruction counter is enabled with INSTR_COUNT_EN.
package ctrl_pkg;

  localparam int OPW = 5;
  localparam int RSW = 4;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_e;

  localparam logic [OPW-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPW-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPW-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OPC_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OPC_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OPC_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OPC_NOT  = 5'b10010;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of IR into opcode and register fields,
// plus opcode classification used by the sequencer.
module ir_field_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]    ir,
  output logic [OPW-1:0] opcode,
  output logic [RSW-1:0] ra,
  output logic [RSW-1:0] rb,
  output logic [RSW-1:0] rc,
  output logic           is_legal,
  output logic           is_unary,
  output logic           is_muldiv
);

  logic unused_bits;

  assign opcode = ir[OP_LSB +: OPW];
  assign ra     = ir[RA_LSB +: RSW];
  assign rb     = ir[RB_LSB +: RSW];
  assign rc     = ir[RC_LSB +: RSW];

  assign unused_bits = ^ir[RC_LSB-1:0];

  assign is_unary  = (opcode == OPC_NEG) ||
                     (opcode == OPC_NOT);
  assign is_muldiv = (opcode == OPC_MUL) ||
                     (opcode == OPC_DIV);

  // Opcodes the register-register execute path supports
  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_ROR, OPC_ROL, OPC_SHR, OPC_SHRA,
      OPC_SHL, OPC_MUL, OPC_DIV, OPC_NEG,
      OPC_NOT: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtl_control_sequencer.sv
// Hardwired fetch/execute control unit driving Datapath strobes.
// Define INSTR_COUNT_EN to add the retired-instruction counter.
module rtl_control_sequencer
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [31:0]    ir,
  output logic           pc_out,
  output logic           pc_increment,
  output logic           MARin,
  output logic           Zlowin,
  output logic           Zhighin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           PCin,
  output logic           read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           RYin,
  output logic           HIin,
  output logic           LOin,
  output logic [OPW-1:0] op_code,
  output logic           rin_en,
  output logic [RSW-1:0] rin_sel,
  output logic           rout_en,
  output logic [RSW-1:0] rout_sel,
  output logic           done,
  output logic           illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]    instr_count
`endif
);

  state_e state_q;
  state_e state_d;

  logic [OPW-1:0] opcode;
  logic [RSW-1:0] ra;
  logic [RSW-1:0] rb;
  logic [RSW-1:0] rc;
  logic           is_legal;
  logic           is_unary;
  logic           is_muldiv;

  ir_field_decode u_dec (
    .ir        (ir),
    .opcode    (opcode),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .is_legal  (is_legal),
    .is_unary  (is_unary),
    .is_muldiv (is_muldiv)
  );

  // Next-state: fetch T0-T2, execute T3-T6, loop on run
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (run) state_d = T0;
      T0:   state_d = T1;
      T1:   state_d = T2;
      T2:   state_d = T3;
      T3: begin
        if (!is_legal) state_d = run ? T0 : IDLE;
        else           state_d = T4;
      end
      T4:   state_d = T5;
      T5: begin
        if (is_muldiv) state_d = T6;
        else           state_d = run ? T0 : IDLE;
      end
      T6:   state_d = run ? T0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; clr aborts immediately to IDLE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Moore strobe decode from state and IR fields
  always_comb begin
    pc_out       = 1'b0;
    pc_increment = 1'b0;
    MARin        = 1'b0;
    Zlowin       = 1'b0;
    Zhighin      = 1'b0;
    Zlowout      = 1'b0;
    Zhighout     = 1'b0;
    PCin         = 1'b0;
    read         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    RYin         = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    op_code      = '0;
    rin_en       = 1'b0;
    rin_sel      = '0;
    rout_en      = 1'b0;
    rout_sel     = '0;
    done         = 1'b0;
    illegal      = 1'b0;
    unique case (state_q)
      IDLE: ;
      T0: begin
        pc_out       = 1'b1;
        pc_increment = 1'b1;
        MARin        = 1'b1;
        Zlowin       = 1'b1;
        Zhighin      = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_legal) begin
          rout_en  = 1'b1;
          rout_sel = rb;
          RYin     = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        rout_en  = 1'b1;
        rout_sel = is_unary ? rb : rc;
        op_code  = opcode;
        Zlowin   = 1'b1;
        Zhighin  = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          rin_en  = 1'b1;
          rin_sel = ra;
          done    = 1'b1;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count_q;
  logic [31:0] instr_count_d;

  // Retired count; wraps naturally at 2^32
  always_comb begin
    instr_count_d = instr_count_q;
    if (done) instr_count_d = instr_count_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_rtl_control_sequencer.sv
// Randomized self-checking bench for rtl_control_sequencer.
// Compares strobes each cycle against a step-table reference model.
module tb_rtl_control_sequencer;

  typedef struct packed {
    logic       pc_out;
    logic       pc_increment;
    logic       MARin;
    logic       Zlowin;
    logic       Zhighin;
    logic       Zlowout;
    logic       Zhighout;
    logic       PCin;
    logic       read;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       RYin;
    logic       HIin;
    logic       LOin;
    logic       rin_en;
    logic       rout_en;
    logic       done;
    logic       illegal;
    logic [4:0] op_code;
    logic [3:0] rin_sel;
    logic [3:0] rout_sel;
  } ctl_t;

  logic        clk;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        pc_out, pc_increment, MARin, Zlowin, Zhighin;
  logic        Zlowout, Zhighout, PCin, read, MDRin, MDRout;
  logic        IRin, RYin, HIin, LOin;
  logic [4:0]  op_code;
  logic        rin_en, rout_en, done, illegal;
  logic [3:0]  rin_sel, rout_sel;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  ctl_t obs;
  int   n_checks;
  int   n_err;
  int   cnt_exp;

  logic [4:0] legal_ops [13] = '{
    5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
    5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
    5'b10000, 5'b10001, 5'b10010
  };

  rtl_control_sequencer dut (
    .clk          (clk),
    .clr          (clr),
    .run          (run),
    .ir           (ir),
    .pc_out       (pc_out),
    .pc_increment (pc_increment),
    .MARin        (MARin),
    .Zlowin       (Zlowin),
    .Zhighin      (Zhighin),
    .Zlowout      (Zlowout),
    .Zhighout     (Zhighout),
    .PCin         (PCin),
    .read         (read),
    .MDRin        (MDRin),
    .MDRout       (MDRout),
    .IRin         (IRin),
    .RYin         (RYin),
    .HIin         (HIin),
    .LOin         (LOin),
    .op_code      (op_code),
    .rin_en       (rin_en),
    .rin_sel      (rin_sel),
    .rout_en      (rout_en),
    .rout_sel     (rout_sel),
    .done         (done),
    .illegal      (illegal)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Register selects only meaningful while their enable is high
  assign obs = {pc_out, pc_increment, MARin, Zlowin, Zhighin,
                Zlowout, Zhighout, PCin, read, MDRin, MDRout,
                IRin, RYin, HIin, LOin, rin_en, rout_en, done,
                illegal, op_code,
                rin_en ? rin_sel : 4'd0,
                rout_en ? rout_sel : 4'd0};

  function automatic bit is_leg(input logic [4:0] op);
    bit r = 0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) r = 1;
    return r;
  endfunction

  function automatic bit is_md(input logic [4:0] op);
    return op == 5'b01111 || op == 5'b10000;
  endfunction

  function automatic int ilen(input logic [4:0] op);
    if (!is_leg(op)) return 4;
    return is_md(op) ? 7 : 6;
  endfunction

  function automatic ctl_t model(input logic [4:0] op,
                                 input logic [3:0] ra,
                                 input logic [3:0] rb,
                                 input logic [3:0] rc,
                                 input int k);
    ctl_t e;
    bit   un;
    e  = '0;
    un = (op == 5'b10001) || (op == 5'b10010);
    case (k)
      0: begin
        e.pc_out = 1; e.pc_increment = 1; e.MARin = 1;
        e.Zlowin = 1; e.Zhighin = 1;
      end
      1: begin
        e.Zlowout = 1; e.PCin = 1; e.read = 1; e.MDRin = 1;
      end
      2: begin
        e.MDRout = 1; e.IRin = 1;
      end
      3: begin
        if (!is_leg(op)) e.illegal = 1;
        else begin
          e.rout_en = 1; e.rout_sel = rb; e.RYin = 1;
        end
      end
      4: begin
        e.rout_en = 1; e.rout_sel = un ? rb : rc;
        e.op_code = op; e.Zlowin = 1; e.Zhighin = 1;
      end
      5: begin
        e.Zlowout = 1;
        if (is_md(op)) e.LOin = 1;
        else begin
          e.rin_en = 1; e.rin_sel = ra; e.done = 1;
        end
      end
      6: begin
        e.Zhighout = 1; e.HIin = 1; e.done = 1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op,
                                        input logic [3:0] ra,
                                        input logic [3:0] rb,
                                        input logic [3:0] rc);
    logic [14:0] tail;
    tail = 15'($urandom);
    return {op, ra, rb, rc, tail};
  endfunction

  // Advance one clock; IR holds stale garbage until it loads after T2
  task automatic advance(input int k, input logic [31:0] word);
    @(posedge clk);
    #1;
    ir = (k < 3) ? $urandom : word;
    #1;
  endtask

  task automatic test_reset;
    clr = 1; run = 0; ir = $urandom;
    #12;
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (instr_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", instr_count);
    end
`endif
    @(negedge clk);
    clr = 0;
    advance(9, $urandom);
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL idle_no_run: got %h want 0", obs);
    end
    cnt_exp = 0;
  endtask

  task automatic test_rol;
    logic [31:0] w;
    ctl_t e;
    w = 32'h421B8000;
    run = 1;
    for (int k = 0; k < 6; k++) begin
      advance(k, w);
      e = model(5'b01000, 4'd4, 4'd3, 4'd7, k);
      cnt_exp += int'(e.done);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL rol step %0d: got %h want %h", k, obs, e);
      end
    end
    run = 0;
    advance(9, $urandom);
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL rol_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_mul;
    logic [3:0] ra, rb, rc;
    logic [31:0] w;
    ctl_t e;
    ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    w = mk_ir(5'b01111, ra, rb, rc);
    run = 1;
    for (int k = 0; k < 7; k++) begin
      advance(k, w);
      e = model(5'b01111, ra, rb, rc, k);
      cnt_exp += int'(e.done);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mul step %0d: got %h want %h", k, obs, e);
      end
    end
    run = 0;
    advance(9, $urandom);
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL mul_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] w;
    logic [3:0] ra, rb, rc;
    ctl_t e;
    run = 1;
    w = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    for (int k = 0; k < 4; k++) begin
      advance(k, w);
      e = model(5'b11111, 4'd1, 4'd2, 4'd3, k);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL illegal step %0d: got %h want %h", k, obs, e);
      end
    end
`ifdef INSTR_COUNT_EN
    advance(0, w);
    n_checks++;
    if (instr_count !== 32'(cnt_exp)) begin
      n_err++;
      $display("FAIL illegal_count: got %0d want %0d",
               instr_count, cnt_exp);
    end
`else
    advance(0, w);
`endif
    ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    w = mk_ir(5'b00011, ra, rb, rc);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) advance(k, w);
      e = model(5'b00011, ra, rb, rc, k);
      cnt_exp += int'(e.done);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL after_illegal step %0d: got %h want %h",
                 k, obs, e);
      end
    end
    run = 0;
    advance(9, $urandom);
  endtask

  task automatic test_back_to_back;
    logic [3:0] ra, rb, rc;
    logic [31:0] w;
    ctl_t e;
    int dones;
    dones = 0;
    run = 1;
    for (int n = 0; n < 3; n++) begin
      ra = 4'($urandom); rb = ra; rc = ra;
      if (n > 0) begin rb = 4'($urandom); rc = 4'($urandom); end
      w = mk_ir(5'b00011, ra, rb, rc);
      for (int k = 0; k < 6; k++) begin
        advance(k, w);
        e = model(5'b00011, ra, rb, rc, k);
        cnt_exp += int'(e.done);
        dones += int'(done);
        n_checks++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL b2b instr %0d step %0d: got %h want %h",
                   n, k, obs, e);
        end
      end
    end
    run = 0;
    n_checks++;
    if (dones != 3) begin
      n_err++;
      $display("FAIL b2b_dones: got %0d want 3", dones);
    end
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (instr_count !== 32'(cnt_exp)) begin
      n_err++;
      $display("FAIL b2b_count: got %0d want %0d",
               instr_count, cnt_exp);
    end
`endif
    advance(9, $urandom);
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL b2b_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] ra, rb, rc;
    logic [31:0] w;
    ctl_t e;
    ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    w = mk_ir(5'b00100, ra, rb, rc);
    run = 1;
    for (int k = 0; k < 5; k++) advance(k, w);
    e = model(5'b00100, ra, rb, rc, 4);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL rmid_t4: got %h want %h", obs, e);
    end
    #2;
    clr = 1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL rmid_async: got %h want 0", obs);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL rmid_held: got %h want 0", obs);
    end
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (instr_count !== 32'd0) begin
      n_err++;
      $display("FAIL rmid_count: got %0d want 0", instr_count);
    end
`endif
    cnt_exp = 0;
    @(negedge clk);
    clr = 0;
    for (int k = 0; k < 6; k++) begin
      advance(k, w);
      e = model(5'b00100, ra, rb, rc, k);
      cnt_exp += int'(e.done);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL rmid_resume step %0d: got %h want %h",
                 k, obs, e);
      end
    end
    run = 0;
    advance(9, $urandom);
  endtask

  task automatic test_run_drop;
    logic [3:0] ra, rb, rc;
    logic [31:0] w;
    ctl_t e;
    ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    w = mk_ir(5'b10001, ra, rb, rc);
    run = 1;
    for (int k = 0; k < 6; k++) begin
      advance(k, w);
      if (k == 3) run = 0;
      e = model(5'b10001, ra, rb, rc, k);
      cnt_exp += int'(e.done);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL drop step %0d: got %h want %h", k, obs, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      advance(9, $urandom);
      n_checks++;
      if (obs !== '0) begin
        n_err++;
        $display("FAIL drop_idle %0d: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [31:0] w;
    ctl_t e;
    int len;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 5'($urandom);
        while (is_leg(op)) op = 5'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 12)];
      end
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      w = mk_ir(op, ra, rb, rc);
      len = ilen(op);
      run = 1;
      for (int k = 0; k < len; k++) begin
        advance(k, w);
        e = model(op, ra, rb, rc, k);
        cnt_exp += int'(e.done);
        n_checks++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL rand %0d op %b step %0d: got %h want %h",
                   n, op, k, obs, e);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        run = 0;
        advance(9, $urandom);
        n_checks++;
        if (obs !== '0) begin
          n_err++;
          $display("FAIL rand_idle %0d: got %h want 0", n, obs);
        end
      end
    end
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (instr_count !== 32'(cnt_exp)) begin
      n_err++;
      $display("FAIL rand_count: got %0d want %0d",
               instr_count, cnt_exp);
    end
`endif
    run = 0;
    advance(9, $urandom);
  endtask

  initial begin
    clk      = 0;
    n_checks = 0;
    n_err    = 0;
    cnt_exp  = 0;
    test_reset;
    test_rol;
    test_mul;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_run_drop;
    test_random;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rtl_control_sequencer.md
Name: rtl_control_sequencer

Overview:
- Hardwired control unit that generates, cycle by cycle, the Datapath control strobes for fetch plus register-register ALU execution.
- Replaces hand-sequenced stimulus: it fetches an instruction word via the MDR path, decodes IR, and emits the T0–T6 RTL micro-steps.
- Sits beside Datapath. Its outputs connect directly to Datapath enables. IR is fed back from Datapath.

Parameters:
- OPW, 5, opcode field width (ir[31:27])
- RSW, 4, register-select width (Ra ir[26:23], Rb ir[22:19], Rc ir[18:15])

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- run  in  1  level; start/continue executing instructions
- ir  in  32  current IR contents from Datapath
- pc_out, pc_increment, MARin, Zlowin, Zhighin  out  1 each  fetch strobes
- Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, RYin  out  1 each
- HIin, LOin  out  1 each  mul/div result capture
- op_code  out  5  ALU operation; nonzero only in T4
- rin_en  out  1  GP register write enable
- rin_sel  out  4  GP register write index
- rout_en  out  1  GP register bus-drive enable
- rout_sel  out  4  GP register bus-drive index
- done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in T3 when the opcode is unsupported

Behaviour:
- Moore FSM; all outputs decode from the registered state plus the ir fields. One state per clock.
- Reset: clr=1 forces state IDLE immediately. All outputs are 0 while clr is held. Reset mid-instruction aborts with no further strobes.
- States and strobes:
  - IDLE: all outputs 0. Goes to T0 when run=1.
  - T0: pc_out, pc_increment, MARin, Zlowin, Zhighin.
  - T1: Zlowout, PCin, read, MDRin.
  - T2: MDRout, IRin.
  - T3: rout_en with rout_sel=Rb, RYin. If the opcode is unsupported: illegal=1, RYin=0, rout_en=0, next state is T0 (run=1) or IDLE.
  - T4: rout_en with rout_sel=Rc (Rb for NEG/NOT), op_code=ir[31:27], Zlowin, Zhighin.
  - T5: Zlowout, rin_en with rin_sel=Ra (ALU ops); Zlowout, LOin (MUL/DIV).
  - T6: MUL/DIV only; Zhighout, HIin.
- done=1 in T5 for ALU ops and in T6 for MUL/DIV.
- After done: T0 if run=1, else IDLE. Dropping run mid-instruction finishes the current instruction.
- Latency from T0 to done: 6 cycles for ALU ops, 7 for MUL/DIV.
- ir is sampled combinationally. It is valid from T3 onward because IR loads at the end of T2.
- Invariants:
  - At most one bus driver is asserted per cycle.
  - rin_en and HIin/LOin are never asserted together.
  - op_code=0 outside T4.
- Ra=Rb=Rc is legal; there is no special handling.

Optional Feature:
- Macro INSTR_COUNT_EN.
- When defined: adds output instr_count[31:0], cleared by clr and incremented on every done pulse. It wraps from 0xFFFFFFFF to 0. Illegal instructions are not counted.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package ctrl_pkg:
  - state enum: IDLE, T0–T6
  - opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010
  - field bit positions
- Sub-module ir_field_decode: combinational. Extracts ra/rb/rc/opcode and computes is_legal, is_unary, is_muldiv.
- The FSM and output decode stay in rtl_control_sequencer.

Test Plan:
- ROL: run=1, ir=0x421B8000 (ROL, Ra=4, Rb=3, Rc=7) once IR loads. Expect:
  - T3: rout_sel=3
  - T4: rout_sel=7, op_code=01000
  - T5: rin_sel=4, rin_en=1, done=1
  - Exactly 6 cycles from T0.
- MUL: ir opcode 01111. Expect LOin+Zlowout in T5, HIin+Zhighout in T6, done in T6, and no rin_en at any point.
- Illegal: ir opcode 11111. Expect illegal=1 in T3, no RYin/rin_en, next state T0. With INSTR_COUNT_EN, instr_count is unchanged.
- Back-to-back: run held high for 3 ADD instructions. Expect T0 directly after each done, 3 done pulses, and (INSTR_COUNT_EN) instr_count=3.
- Reset mid-instruction: assert clr during T4. Expect all outputs 0 asynchronously, state IDLE. After release with run=1, the next cycle is T0.
- Run drop: deassert run during T3. Expect the instruction to complete with done, then IDLE with all outputs 0.
